// File: rtl/axi4_lite_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_if
// Purpose  : AXI4-Lite bus bundle with master and slave modports.
// Revision : 1.0 - initial release
// ============================================================================
interface axi4_lite_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) ();
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slv_port (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

    modport mst_port (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_reg_bank
// Purpose  : AXI4-Lite slave with RW control and RO status registers,
//            byte-strobe merging and sticky clear-on-read status bits.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_reg_bank #(
    parameter int                         DATA_W        = 32,
    parameter int                         ADDR_W        = 12,
    parameter int                         N_CTRL        = 4,
    parameter int                         N_STAT        = 4,
    parameter logic [N_CTRL*DATA_W-1:0]   CTRL_RST_VAL  = '0,
    parameter logic [N_STAT*DATA_W-1:0]   STAT_COR_MASK = '0
) (
    input  logic                       i_clk,
    input  logic                       i_arst_n,
    axi4_lite_if.slv_port              if_s_axi4_lite,
    output logic [N_CTRL*DATA_W-1:0]   o_ctrl,
    output logic [N_CTRL-1:0]          o_ctrl_wr_pulse,
    input  logic [N_CTRL-1:0]          i_ctrl_hw_we,
    input  logic [N_CTRL*DATA_W-1:0]   i_ctrl_hw_wdata,
    input  logic [N_STAT*DATA_W-1:0]   i_stat,
    output logic [N_STAT-1:0]          o_stat_rd_pulse
);

    localparam int         c_STRB_W      = DATA_W / 8;
    localparam int         c_LSB         = $clog2(c_STRB_W);
    localparam int         c_IDX_W       = ADDR_W - c_LSB;
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    // write channel state
    logic                r_aw_full, r_w_full, r_awready, r_wready, r_bvalid;
    logic [c_IDX_W-1:0]  r_aw_idx;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_STRB_W-1:0] r_wstrb;
    logic [1:0]          r_bresp;
    logic                w_aw_hs, w_w_hs, w_b_hs, w_commit, w_wr_is_ctrl;
    logic                w_aw_full_nxt, w_w_full_nxt, w_bvalid_nxt;
    logic [DATA_W-1:0]   w_wr_mask;

    // read channel state
    logic                r_arready, r_rvalid;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_rresp;
    logic                w_ar_hs, w_r_hs, w_rvalid_nxt;
    logic [c_IDX_W-1:0]  w_ar_idx;
    logic [DATA_W-1:0]   w_rd_data;
    logic [1:0]          w_rd_resp;
    logic [N_STAT-1:0]   w_stat_sel;
    logic [N_STAT-1:0]   r_stat_rd_pulse;

    // register storage
    logic [DATA_W-1:0]   r_ctrl     [N_CTRL];
    logic [DATA_W-1:0]   w_ctrl_nxt [N_CTRL];
    logic [N_CTRL-1:0]   w_ctrl_wr_sel;
    logic [N_CTRL-1:0]   r_ctrl_wr_pulse;
    logic [DATA_W-1:0]   w_stat_view [N_STAT];

    logic                w_unused;
    assign w_unused = &{1'b0, if_s_axi4_lite.awaddr[c_LSB-1:0],
                        if_s_axi4_lite.araddr[c_LSB-1:0],
                        if_s_axi4_lite.awprot, if_s_axi4_lite.arprot};

    assign w_aw_hs  = if_s_axi4_lite.awvalid && r_awready;
    assign w_w_hs   = if_s_axi4_lite.wvalid  && r_wready;
    assign w_b_hs   = r_bvalid && if_s_axi4_lite.bready;
    assign w_commit = r_aw_full && r_w_full;
    assign w_wr_is_ctrl = (32'(r_aw_idx) < N_CTRL);

    always_comb begin
        w_aw_full_nxt = w_commit ? 1'b0 : (r_aw_full | w_aw_hs);
        w_w_full_nxt  = w_commit ? 1'b0 : (r_w_full  | w_w_hs);
        w_bvalid_nxt  = w_commit ? 1'b1 : (w_b_hs ? 1'b0 : r_bvalid);
        for (int b = 0; b < c_STRB_W; b++) begin
            w_wr_mask[b*8 +: 8] = {8{r_wstrb[b]}};
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
        end else begin
            r_aw_full <= w_aw_full_nxt;
            r_w_full  <= w_w_full_nxt;
            r_awready <= !w_aw_full_nxt && !w_bvalid_nxt;
            r_wready  <= !w_w_full_nxt  && !w_bvalid_nxt;
            r_bvalid  <= w_bvalid_nxt;
            if (w_aw_hs) begin
                r_aw_idx <= if_s_axi4_lite.awaddr[ADDR_W-1:c_LSB];
            end
            if (w_w_hs) begin
                r_wdata <= if_s_axi4_lite.wdata;
                r_wstrb <= if_s_axi4_lite.wstrb;
            end
            if (w_commit) begin
                r_bresp <= w_wr_is_ctrl ? c_RESP_OKAY : c_RESP_SLVERR;
            end
        end
    end

    // Hardware value forms the base word; strobed software lanes override it.
    always_comb begin
        for (int k = 0; k < N_CTRL; k++) begin
            w_ctrl_wr_sel[k] = w_commit && (32'(r_aw_idx) == k);
            w_ctrl_nxt[k]    = i_ctrl_hw_we[k] ? i_ctrl_hw_wdata[k*DATA_W +: DATA_W] : r_ctrl[k];
            if (w_ctrl_wr_sel[k]) begin
                w_ctrl_nxt[k] = (w_ctrl_nxt[k] & ~w_wr_mask) | (r_wdata & w_wr_mask);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int k = 0; k < N_CTRL; k++) begin
                r_ctrl[k] <= CTRL_RST_VAL[k*DATA_W +: DATA_W];
            end
            r_ctrl_wr_pulse <= '0;
        end else begin
            for (int k = 0; k < N_CTRL; k++) begin
                r_ctrl[k] <= w_ctrl_nxt[k];
            end
            r_ctrl_wr_pulse <= w_ctrl_wr_sel;
        end
    end

    assign w_ar_hs  = if_s_axi4_lite.arvalid && r_arready;
    assign w_r_hs   = r_rvalid && if_s_axi4_lite.rready;
    assign w_ar_idx = if_s_axi4_lite.araddr[ADDR_W-1:c_LSB];
    assign w_rvalid_nxt = w_ar_hs ? 1'b1 : (w_r_hs ? 1'b0 : r_rvalid);

    always_comb begin
        w_rd_data  = '0;
        w_rd_resp  = c_RESP_SLVERR;
        w_stat_sel = '0;
        for (int k = 0; k < N_CTRL; k++) begin
            if (32'(w_ar_idx) == k) begin
                w_rd_data = r_ctrl[k];
                w_rd_resp = c_RESP_OKAY;
            end
        end
        for (int k = 0; k < N_STAT; k++) begin
            if (32'(w_ar_idx) == N_CTRL + k) begin
                w_rd_data     = w_stat_view[k];
                w_rd_resp     = c_RESP_OKAY;
                w_stat_sel[k] = 1'b1;
            end
        end
    end

    // Sticky bits: a set in the read cycle survives because the returned
    // value comes from the pre-update register.
    generate
        for (genvar k = 0; k < N_STAT; k++) begin : g_stat
            localparam logic [DATA_W-1:0] c_MASK = STAT_COR_MASK[k*DATA_W +: DATA_W];
            logic [DATA_W-1:0] r_sticky;
            logic [DATA_W-1:0] w_stat_in;

            assign w_stat_in      = i_stat[k*DATA_W +: DATA_W];
            assign w_stat_view[k] = (w_stat_in & ~c_MASK) | (r_sticky & c_MASK);

            always_ff @(posedge i_clk or negedge i_arst_n) begin
                if (!i_arst_n) begin
                    r_sticky <= '0;
                end else begin
                    r_sticky <= ((w_ar_hs && w_stat_sel[k]) ? '0 : r_sticky) | (w_stat_in & c_MASK);
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_arready       <= 1'b0;
            r_rvalid        <= 1'b0;
            r_rdata         <= '0;
            r_rresp         <= c_RESP_OKAY;
            r_stat_rd_pulse <= '0;
        end else begin
            r_arready       <= !w_rvalid_nxt;
            r_rvalid        <= w_rvalid_nxt;
            r_stat_rd_pulse <= w_ar_hs ? w_stat_sel : '0;
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
            end
        end
    end

    generate
        for (genvar k = 0; k < N_CTRL; k++) begin : g_ctrl_out
            assign o_ctrl[k*DATA_W +: DATA_W] = r_ctrl[k];
        end
    endgenerate

    assign o_ctrl_wr_pulse        = r_ctrl_wr_pulse;
    assign o_stat_rd_pulse        = r_stat_rd_pulse;
    assign if_s_axi4_lite.awready = r_awready;
    assign if_s_axi4_lite.wready  = r_wready;
    assign if_s_axi4_lite.bvalid  = r_bvalid;
    assign if_s_axi4_lite.bresp   = r_bresp;
    assign if_s_axi4_lite.arready = r_arready;
    assign if_s_axi4_lite.rvalid  = r_rvalid;
    assign if_s_axi4_lite.rdata   = r_rdata;
    assign if_s_axi4_lite.rresp   = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_reg_bank
// Purpose  : Directed vector table plus corner sequences for the register bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_reg_bank;

    localparam logic [127:0] c_RST = {32'hA5A5_0000, 32'h0, 32'h0, 32'hDEAD_BEEF};
    localparam logic [127:0] c_COR = {96'h0, 32'h0000_0001};
    localparam int           c_BUDGET = 50;

    logic         i_clk = 1'b0;
    logic         i_arst_n = 1'b0;
    logic [127:0] o_ctrl;
    logic [3:0]   o_ctrl_wr_pulse;
    logic [3:0]   i_ctrl_hw_we = '0;
    logic [127:0] i_ctrl_hw_wdata = '0;
    logic [127:0] i_stat = {32'h8000_0000, 32'h1357_9BDF, 32'hCAFE_0001, 32'h0000_1230};
    logic [3:0]   o_stat_rd_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    axi4_lite_if #(.DATA_W(32), .ADDR_W(12)) u_if ();

    axi4_lite_reg_bank #(
        .DATA_W(32), .ADDR_W(12), .N_CTRL(4), .N_STAT(4),
        .CTRL_RST_VAL(c_RST), .STAT_COR_MASK(c_COR)
    ) u_dut (
        .i_clk           (i_clk),
        .i_arst_n        (i_arst_n),
        .if_s_axi4_lite  (u_if.slv_port),
        .o_ctrl          (o_ctrl),
        .o_ctrl_wr_pulse (o_ctrl_wr_pulse),
        .i_ctrl_hw_we    (i_ctrl_hw_we),
        .i_ctrl_hw_wdata (i_ctrl_hw_wdata),
        .i_stat          (i_stat),
        .o_stat_rd_pulse (o_stat_rd_pulse)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [3:0]  pulse;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out after %0d cycles", name, c_BUDGET);
    endtask

    task automatic wait_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_aw(input logic [11:0] addr);
        bit hs = 0;
        u_if.awaddr  = addr;
        u_if.awvalid = 1'b1;
        for (int i = 0; i < c_BUDGET && !hs; i++) begin
            hs = u_if.awready;
            wait_cycle();
        end
        u_if.awvalid = 1'b0;
        if (!hs) timeout_fail("aw_handshake");
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        bit hs = 0;
        u_if.wdata  = data;
        u_if.wstrb  = strb;
        u_if.wvalid = 1'b1;
        for (int i = 0; i < c_BUDGET && !hs; i++) begin
            hs = u_if.wready;
            wait_cycle();
        end
        u_if.wvalid = 1'b0;
        if (!hs) timeout_fail("w_handshake");
    endtask

    task automatic send_ar(input logic [11:0] addr);
        bit hs = 0;
        u_if.araddr  = addr;
        u_if.arvalid = 1'b1;
        for (int i = 0; i < c_BUDGET && !hs; i++) begin
            hs = u_if.arready;
            wait_cycle();
        end
        u_if.arvalid = 1'b0;
        if (!hs) timeout_fail("ar_handshake");
    endtask

    // Pulse outputs are captured in the cycle the response first appears.
    task automatic wait_b(output logic [1:0] resp, output logic [3:0] pulse);
        bit seen = 0;
        resp = 'x;
        pulse = 'x;
        u_if.bready = 1'b1;
        for (int i = 0; i < c_BUDGET && !seen; i++) begin
            if (u_if.bvalid) begin
                seen  = 1;
                resp  = u_if.bresp;
                pulse = o_ctrl_wr_pulse;
            end
            wait_cycle();
        end
        u_if.bready = 1'b0;
        if (!seen) timeout_fail("b_response");
    endtask

    task automatic wait_r(output logic [31:0] data, output logic [1:0] resp, output logic [3:0] pulse);
        bit seen = 0;
        data = 'x;
        resp = 'x;
        pulse = 'x;
        u_if.rready = 1'b1;
        for (int i = 0; i < c_BUDGET && !seen; i++) begin
            if (u_if.rvalid) begin
                seen  = 1;
                data  = u_if.rdata;
                resp  = u_if.rresp;
                pulse = o_stat_rd_pulse;
            end
            wait_cycle();
        end
        u_if.rready = 1'b0;
        if (!seen) timeout_fail("r_response");
    endtask

    task automatic do_read(input string name, input logic [11:0] addr,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        logic [3:0]  p;
        send_ar(addr);
        wait_r(d, r, p);
        check({name, " rdata"}, d, exp_data);
        check({name, " rresp"}, r, exp_resp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [3:0]  p;

        vecs[0]  = '{1'b0, 12'h000, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF, 4'b0000};
        vecs[1]  = '{1'b0, 12'h00C, 32'h0,         4'h0, 2'b00, 32'hA5A5_0000, 4'b0000};
        vecs[2]  = '{1'b1, 12'h004, 32'h1234_5678, 4'hF, 2'b00, 32'h0,         4'b0010};
        vecs[3]  = '{1'b0, 12'h004, 32'h0,         4'h0, 2'b00, 32'h1234_5678, 4'b0000};
        vecs[4]  = '{1'b1, 12'h006, 32'hAABB_CCDD, 4'h8, 2'b00, 32'h0,         4'b0010};
        vecs[5]  = '{1'b0, 12'h005, 32'h0,         4'h0, 2'b00, 32'hAA34_5678, 4'b0000};
        vecs[6]  = '{1'b1, 12'h010, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0,         4'b0000};
        vecs[7]  = '{1'b0, 12'h010, 32'h0,         4'h0, 2'b00, 32'h0000_1230, 4'b0001};
        vecs[8]  = '{1'b0, 12'h014, 32'h0,         4'h0, 2'b00, 32'hCAFE_0001, 4'b0010};
        vecs[9]  = '{1'b0, 12'h01C, 32'h0,         4'h0, 2'b00, 32'h8000_0000, 4'b1000};
        vecs[10] = '{1'b1, 12'h020, 32'h5555_5555, 4'hF, 2'b10, 32'h0,         4'b0000};
        vecs[11] = '{1'b0, 12'h020, 32'h0,         4'h0, 2'b10, 32'h0,         4'b0000};
        vecs[12] = '{1'b0, 12'hFFC, 32'h0,         4'h0, 2'b10, 32'h0,         4'b0000};
        vecs[13] = '{1'b1, 12'h00C, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0,         4'b1000};
        vecs[14] = '{1'b0, 12'h00C, 32'h0,         4'h0, 2'b00, 32'hA5A5_0000, 4'b0000};

        u_if.awaddr = '0; u_if.awprot = '0; u_if.awvalid = 1'b0;
        u_if.wdata  = '0; u_if.wstrb  = '0; u_if.wvalid  = 1'b0;
        u_if.bready = 1'b0;
        u_if.araddr = '0; u_if.arprot = '0; u_if.arvalid = 1'b0;
        u_if.rready = 1'b0;

        // reset state and first edge after release
        repeat (3) wait_cycle();
        check("rst readies", {u_if.awready, u_if.wready, u_if.arready}, 3'b000);
        check("rst valids", {u_if.bvalid, u_if.rvalid}, 2'b00);
        check("rst o_ctrl", o_ctrl, c_RST);
        i_arst_n = 1'b1;
        check("release arready", u_if.arready, 1'b0);
        wait_cycle();
        check("post-release readies", {u_if.awready, u_if.wready, u_if.arready}, 3'b111);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                fork
                    send_aw(vecs[i].addr);
                    send_w(vecs[i].wdata, vecs[i].strb);
                join
                wait_b(r, p);
                check($sformatf("vec%0d bresp", i), r, vecs[i].resp);
                check($sformatf("vec%0d wr_pulse", i), p, vecs[i].pulse);
            end else begin
                send_ar(vecs[i].addr);
                wait_r(d, r, p);
                check($sformatf("vec%0d rdata", i), d, vecs[i].rdata);
                check($sformatf("vec%0d rresp", i), r, vecs[i].resp);
                check($sformatf("vec%0d rd_pulse", i), p, vecs[i].pulse);
            end
        end
        check("o_ctrl after table", o_ctrl, {32'hA5A5_0000, 32'h0, 32'hAA34_5678, 32'hDEAD_BEEF});

        // reset asserted while a read response is pending
        send_ar(12'h000);
        check("mid-read rvalid", u_if.rvalid, 1'b1);
        #1 i_arst_n = 1'b0;
        #1;
        check("async rst rvalid", u_if.rvalid, 1'b0);
        check("async rst arready", u_if.arready, 1'b0);
        check("async rst o_ctrl", o_ctrl, c_RST);
        repeat (2) wait_cycle();
        i_arst_n = 1'b1;
        check("mid-read release arready", u_if.arready, 1'b0);
        wait_cycle();
        check("mid-read reopen", {u_if.awready, u_if.wready, u_if.arready}, 3'b111);
        check("abandoned read", u_if.rvalid, 1'b0);

        // W ahead of AW, strobed lanes into a reset-zero register
        send_w(32'h1122_3344, 4'b0101);
        check("w-first wready", u_if.wready, 1'b0);
        repeat (3) wait_cycle();
        check("w-first no bvalid", u_if.bvalid, 1'b0);
        send_aw(12'h004);
        wait_b(r, p);
        check("w-first bresp", r, 2'b00);
        check("w-first pulse", p, 4'b0010);
        check("w-first o_ctrl1", o_ctrl[63:32], 32'h0022_0044);
        check("w-first pulse gone", o_ctrl_wr_pulse, 4'b0000);

        // hardware write colliding with a software commit
        fork
            send_aw(12'h008);
            send_w(32'h0, 4'b0011);
        join
        i_ctrl_hw_we = 4'b0100;
        i_ctrl_hw_wdata[95:64] = 32'hFFFF_FFFF;
        wait_cycle();
        i_ctrl_hw_we = 4'b0000;
        check("collision o_ctrl2", o_ctrl[95:64], 32'hFFFF_0000);
        wait_b(r, p);
        check("collision pulse", p, 4'b0100);
        i_ctrl_hw_we = 4'b1000;
        i_ctrl_hw_wdata[127:96] = 32'h0BAD_F00D;
        wait_cycle();
        i_ctrl_hw_we = 4'b0000;
        check("hw-only o_ctrl3", o_ctrl[127:96], 32'h0BAD_F00D);

        // clear-on-read, set pulse ahead of the read
        i_stat[0] = 1'b1;
        wait_cycle();
        i_stat[0] = 1'b0;
        do_read("cor first", 12'h010, 32'h0000_1231, 2'b00);
        do_read("cor second", 12'h010, 32'h0000_1230, 2'b00);

        // clear-on-read, set pulse in the handshake cycle
        i_stat[0] = 1'b1;
        check("cor coincident arready", u_if.arready, 1'b1);
        send_ar(12'h010);
        i_stat[0] = 1'b0;
        wait_r(d, r, p);
        check("cor coincident rdata", d, 32'h0000_1230);
        check("cor coincident pulse", p, 4'b0001);
        do_read("cor held", 12'h010, 32'h0000_1231, 2'b00);
        do_read("cor cleared", 12'h010, 32'h0000_1230, 2'b00);

        // B channel backpressure on an error response
        fork
            send_aw(12'h018);
            send_w(32'h5555_AAAA, 4'hF);
        join
        wait_cycle();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("b stall%0d", i),
                  {u_if.bvalid, u_if.bresp, u_if.awready, u_if.wready}, 5'b1_10_00);
            wait_cycle();
        end
        wait_b(r, p);
        check("b stall bresp", r, 2'b10);
        check("b reopen", {u_if.awready, u_if.wready}, 2'b11);

        // R channel backpressure while the source register changes
        send_ar(12'h000);
        i_ctrl_hw_we = 4'b0001;
        i_ctrl_hw_wdata[31:0] = 32'h0;
        wait_cycle();
        i_ctrl_hw_we = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("r stall%0d", i),
                  {u_if.rvalid, u_if.arready, u_if.rdata}, {1'b1, 1'b0, 32'hDEAD_BEEF});
            wait_cycle();
        end
        wait_r(d, r, p);
        check("r stall rdata", d, 32'hDEAD_BEEF);
        check("r reopen", u_if.arready, 1'b1);
        do_read("r after hw", 12'h000, 32'h0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
